pc_stack_unit: RTL

Parametrised program-counter unit for the PIC10F200-class core: PC register plus an integrated circular return-address stack. Executes increment, skip, GOTO, CALL, RETLW and computed PCL writes under one registered operation code per instruction cycle. Sits between the instruction decoder/ALU (operation and target sources) and program memory (fetch address).

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_ret_stack.sv | 84 ++++++++
 rtl/pc_stack_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Operation encoding and default widths shared by the PC unit
//               and its return stack.
// Revision    : 1.0
// ============================================================================
package pc_pkg;

    localparam int unsigned c_PC_W        = 9;
    localparam int unsigned c_CALL_W      = 8;
    localparam int unsigned c_STACK_DEPTH = 2;

    // Encoding 3'd7 is deliberately unnamed; the unit treats it as a hold.
    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_SKIP = 3'd2,
        PC_GOTO = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5,
        PC_LDL  = 3'd6
    } pc_op_t;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_ret_stack
// Description : Circular return-address stack. With PC_STACK_FLAGS_EN it also
//               keeps a saturating occupancy count and sticky ovf/unf flags.
// Revision    : 1.0
// ============================================================================
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int unsigned PC_W        = c_PC_W,
    parameter int unsigned STACK_DEPTH = c_STACK_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [PC_W-1:0]                push_data_i,
    output logic [PC_W-1:0]                pop_data_o,
    output logic [$clog2(STACK_DEPTH)-1:0] sp_o
`ifdef PC_STACK_FLAGS_EN
    ,
    output logic                           ovf_o,
    output logic                           unf_o
`endif
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0] sp_q;

    // Pop reads the slot below the pointer, so a RET right after a CALL
    // returns the address that CALL just wrote.
    assign pop_data_o = stack_q[sp_q - SP_W'(1)];
    assign sp_o       = sp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_i) begin
            stack_q[sp_q] <= push_data_i;
            sp_q          <= sp_q + SP_W'(1);
        end else if (pop_i) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

`ifdef PC_STACK_FLAGS_EN
    localparam int unsigned OCC_W = $clog2(STACK_DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic             ovf_q;
    logic             unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push_i) begin
            if (occ_q == OCC_W'(STACK_DEPTH)) begin
                ovf_q <= 1'b1;
            end else begin
                occ_q <= occ_q + OCC_W'(1);
            end
        end else if (pop_i) begin
            if (occ_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`endif

endmodule : pc_ret_stack
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit
// Description : PC register, next-PC mux and circular return stack.
//               Optional macro PC_STACK_FLAGS_EN adds stk_ovf/stk_unf ports.
// Revision    : 1.0
// ============================================================================
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W        = c_PC_W,
    parameter int unsigned     CALL_W      = c_CALL_W,
    parameter int unsigned     STACK_DEPTH = c_STACK_DEPTH,
    parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  pc_op_t                         op,
    input  logic [PC_W-1:0]                target,
    input  logic [CALL_W-1:0]              pcl_in,
    output logic [PC_W-1:0]                pc_out,
    output logic [$clog2(STACK_DEPTH)-1:0] sp_out
`ifdef PC_STACK_FLAGS_EN
    ,
    output logic                           stk_ovf,
    output logic                           stk_unf
`endif
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_pop_data;
    logic            w_push;
    logic            w_pop;

    assign w_pc_plus1 = pc_q + PC_W'(1);
    assign w_push     = ce && (op == PC_CALL);
    assign w_pop      = ce && (op == PC_RET);

    always_comb begin
        pc_d = pc_q;
        if (ce) begin
            case (op)
                PC_INC:  pc_d = w_pc_plus1;
                PC_SKIP: pc_d = pc_q + PC_W'(2);
                PC_GOTO: pc_d = target;
                PC_CALL: pc_d = PC_W'(target[CALL_W-1:0]);
                PC_RET:  pc_d = w_pop_data;
                PC_LDL:  pc_d = PC_W'(pcl_in);
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

    // CALL ignores the upper target bits by design.
    generate
        if (CALL_W < PC_W) begin : g_unused_target
            logic w_unused_target_hi;
            assign w_unused_target_hi = ^target[PC_W-1:CALL_W];
        end
    endgenerate

    pc_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_data_i (w_pc_plus1),
        .pop_data_o  (w_pop_data),
        .sp_o        (sp_out)
`ifdef PC_STACK_FLAGS_EN
        ,
        .ovf_o       (stk_ovf),
        .unf_o       (stk_unf)
`endif
    );

endmodule : pc_stack_unit
`default_nettype wire
